// File: rtl/demux1x2x32_buf_if.sv
// demux1x2x32_buf_if: input stream plus two output streams; DEMUX_CNT_EN adds counter signals
interface demux1x2x32_buf_if;
  logic [31:0] D;
  logic        S;
  logic        In_valid;
  logic        In_ready;
  logic [31:0] Y0;
  logic [31:0] Y1;
  logic        Y0_valid;
  logic        Y1_valid;
  logic        Y0_ready;
  logic        Y1_ready;
`ifdef DEMUX_CNT_EN
  logic        Cnt_clr;
  logic [15:0] Cnt0;
  logic [15:0] Cnt1;
  modport slave (input D, S, In_valid, Y0_ready, Y1_ready, Cnt_clr,
                 output In_ready, Y0, Y1, Y0_valid, Y1_valid, Cnt0, Cnt1);
  modport master (output D, S, In_valid, Y0_ready, Y1_ready, Cnt_clr,
                  input In_ready, Y0, Y1, Y0_valid, Y1_valid, Cnt0, Cnt1);
`else
  modport slave (input D, S, In_valid, Y0_ready, Y1_ready,
                 output In_ready, Y0, Y1, Y0_valid, Y1_valid);
  modport master (output D, S, In_valid, Y0_ready, Y1_ready,
                  input In_ready, Y0, Y1, Y0_valid, Y1_valid);
`endif
endinterface

// File: rtl/demux1x2x32_buf.sv
// demux1x2x32_buf: 1-to-2 demux with one-entry skid-free buffer per channel; DEMUX_CNT_EN adds transfer counters
module demux1x2x32_buf (
  input logic Clk,
  input logic Clrn,
  demux1x2x32_buf_if.slave bus
);
  logic ld0, ld1, out0, out1;
  assign bus.In_ready = bus.S ? (!bus.Y1_valid || bus.Y1_ready) : (!bus.Y0_valid || bus.Y0_ready);
  assign ld0  = bus.In_valid && bus.In_ready && !bus.S;
  assign ld1  = bus.In_valid && bus.In_ready && bus.S;
  assign out0 = bus.Y0_valid && bus.Y0_ready;
  assign out1 = bus.Y1_valid && bus.Y1_ready;
  always_ff @(posedge Clk or negedge Clrn)
    if (!Clrn) begin
      bus.Y0       <= 32'h0;
      bus.Y1       <= 32'h0;
      bus.Y0_valid <= 1'b0;
      bus.Y1_valid <= 1'b0;
    end else begin
      if (ld0) bus.Y0 <= bus.D;
      if (ld1) bus.Y1 <= bus.D;
      bus.Y0_valid <= ld0 || (bus.Y0_valid && !out0);
      bus.Y1_valid <= ld1 || (bus.Y1_valid && !out1);
    end
`ifdef DEMUX_CNT_EN
  always_ff @(posedge Clk or negedge Clrn)
    if (!Clrn) begin
      bus.Cnt0 <= 16'h0;
      bus.Cnt1 <= 16'h0;
    end else if (bus.Cnt_clr) begin
      bus.Cnt0 <= 16'h0;
      bus.Cnt1 <= 16'h0;
    end else begin
      if (out0 && bus.Cnt0 != 16'hFFFF) bus.Cnt0 <= bus.Cnt0 + 16'd1;
      if (out1 && bus.Cnt1 != 16'hFFFF) bus.Cnt1 <= bus.Cnt1 + 16'd1;
    end
`endif
endmodule
